mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 43 ++++
 rtl/mc_control_decoder.sv | 67 ++++++
 rtl/mc_control.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared opcode, ALU code and state encodings for the multicycle controller
package mc_control_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_DEC  = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef struct packed {
    logic       alu_wb;     // EX goes straight to WB
    logic       load;
    logic       store;
    logic       byte_acc;
    logic       imm;
    logic       rd_b;
    logic       br_uncond;
    logic       br_eq;
    logic       br_ne;
    logic [3:0] alu_func;
  } dec_t;

endpackage

// File: rtl/mc_control_decoder.sv
// rtl/mc_control_decoder.sv - combinational opcode-to-class decoder (mc_decoder)
module mc_decoder
  import mc_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] func_lo,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.alu_wb   = 1'b1;
        dec.alu_func = func_lo;
      end
      OP_LI, OP_LUI, OP_ADDI: begin
        dec.alu_wb   = 1'b1;
        dec.imm      = 1'b1;
        dec.alu_func = ALU_ADD;
      end
      OP_ANDI: begin
        dec.alu_wb   = 1'b1;
        dec.imm      = 1'b1;
        dec.alu_func = ALU_AND;
      end
      OP_ORI: begin
        dec.alu_wb   = 1'b1;
        dec.imm      = 1'b1;
        dec.alu_func = ALU_OR;
      end
      OP_B: dec.br_uncond = 1'b1;
      OP_BEQ: begin
        dec.br_eq    = 1'b1;
        dec.rd_b     = 1'b1;
        dec.alu_func = ALU_SUB;
      end
      OP_BNE: begin
        dec.br_ne    = 1'b1;
        dec.rd_b     = 1'b1;
        dec.alu_func = ALU_SUB;
      end
      OP_LW: begin
        dec.load = 1'b1;
        dec.imm  = 1'b1;
      end
      OP_LB: begin
        dec.load     = 1'b1;
        dec.imm      = 1'b1;
        dec.byte_acc = 1'b1;
      end
      OP_SW: begin
        dec.store = 1'b1;
        dec.imm   = 1'b1;
        dec.rd_b  = 1'b1;
      end
      OP_SB: begin
        dec.store    = 1'b1;
        dec.imm      = 1'b1;
        dec.rd_b     = 1'b1;
        dec.byte_acc = 1'b1;
      end
      default: ; // illegal opcodes fall through as a NOP
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle CPU control FSM with variable-latency memory stage
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        Mem_In_Out_Sel,
  output logic [2:0]  state
);

  localparam logic [3:0] MEM_INIT = 4'(MEM_WAIT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dec_t       dec;
  logic       active;
  logic       is_ctrl;
  logic       unused_instr;

  assign unused_instr = ^instr[25:4];

  mc_decoder u_decoder (
    .opcode  (instr[31:26]),
    .func_lo (instr[3:0]),
    .dec     (dec)
  );

  // Branches and illegal opcodes retire in EX.
  assign is_ctrl = ~(dec.alu_wb | dec.load | dec.store);
  assign active  = (state_q == ST_DEC) || (state_q == ST_EX) ||
                   (state_q == ST_MEM) || (state_q == ST_WB);
  assign state   = state_q;

  always_comb begin
    state_d = ST_IF;
    cnt_d   = 4'd0;
    case (state_q)
      ST_IDLE: state_d = ST_IF;
      ST_IF:   state_d = ST_DEC;
      ST_DEC:  state_d = ST_EX;
      ST_EX: begin
        if (dec.alu_wb) begin
          state_d = ST_WB;
        end else if (dec.load || dec.store) begin
          state_d = ST_MEM;
          cnt_d   = MEM_INIT;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        if (cnt_q != 4'd0) begin
          state_d = ST_MEM;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = dec.load ? ST_WB : ST_IF;
        end
      end
      ST_WB:   state_d = ST_IF;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from state_q, so the async reset clears them at once.
  always_comb begin
    IR_LdEn        = (state_q == ST_IF);
    PC_LdEn        = 1'b0;
    PC_sel         = 1'b0;
    RF_WrEn        = 1'b0;
    RF_WrData_sel  = 1'b0;
    RF_B_sel       = 1'b0;
    ALU_Bin_sel    = 1'b0;
    ALU_func       = 4'd0;
    Mem_WrEn       = 1'b0;
    Mem_In_Out_Sel = 1'b0;
    if (active) begin
      ALU_func    = dec.alu_func;
      ALU_Bin_sel = dec.imm;
      RF_B_sel    = dec.rd_b;
    end
    case (state_q)
      ST_EX: begin
        if (is_ctrl) begin
          PC_LdEn = 1'b1;
          PC_sel  = dec.br_uncond | (dec.br_eq & alu_zero) | (dec.br_ne & ~alu_zero);
        end
      end
      ST_MEM: begin
        Mem_In_Out_Sel = dec.byte_acc;
        Mem_WrEn       = dec.store && (cnt_q == MEM_INIT);
        PC_LdEn        = dec.store && (cnt_q == 4'd0);
      end
      ST_WB: begin
        RF_WrEn        = 1'b1;
        RF_WrData_sel  = dec.load;
        PC_LdEn        = 1'b1;
        Mem_In_Out_Sel = dec.byte_acc;
      end
      default: ;
    endcase
  end

endmodule
